// File: rtl/sdr_pkg.sv
// Shared definitions for the FT600 stream demultiplexer: header layout,
// reserved channel ids and the parser state encoding.
package sdr_pkg;

    localparam logic [3:0] HDR_MAGIC = 4'hA;
    localparam int         MAGIC_LSB = 28;
    localparam int         ID_LSB    = 24;
    localparam int         LEN_LSB   = 0;
    localparam int         LEN_W     = 16;
    localparam logic [3:0] CPU_ID    = 4'hF;

    typedef enum logic [1:0] {
        ST_HDR     = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DROP    = 2'd2
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc_i,
    output logic [CNT_WIDTH-1:0] count_o
);

    logic [CNT_WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/ft_stream_demux.sv
// Splits the FT600 read stream into per-channel IQ samples and CPU control
// words, framed by length-prefixed headers.
module ft_stream_demux
    import sdr_pkg::*;
#(
    parameter int FT_DATA_WIDTH    = 32,
    parameter int IQ_PAIR_WIDTH    = 24,
    parameter int QSTART_BIT_INDEX = 16,
    parameter int NUM_CH           = 2,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [FT_DATA_WIDTH-1:0]        data_i,
    input  logic                            we_i,
    output logic                            full_o,
    output logic                            enough_o,
    input  logic [NUM_CH-1:0]               fifo_full_i,
    input  logic [NUM_CH-1:0]               fifo_enough_i,
    output logic [NUM_CH*IQ_PAIR_WIDTH-1:0] fifo_data_o,
    output logic [NUM_CH-1:0]               fifo_we_o,
    output logic [FT_DATA_WIDTH-1:0]        cpu_data_o,
    output logic                            cpu_we_o,
    input  logic                            cpu_full_i,
    output logic [CNT_WIDTH-1:0]            hdr_err_o,
    output logic [CNT_WIDTH-1:0]            ovf_err_o,
    output logic                            busy_o
);

    localparam int HALF = IQ_PAIR_WIDTH / 2;

    state_e                          state_q, state_d;
    logic [LEN_W-1:0]                remaining_q, remaining_d;
    logic [3:0]                      id_q, id_d;
    logic [NUM_CH-1:0]               fifo_we_q, fifo_we_d;
    logic [NUM_CH*IQ_PAIR_WIDTH-1:0] fifo_data_q, fifo_data_d;
    logic                            cpu_we_q, cpu_we_d;
    logic [FT_DATA_WIDTH-1:0]        cpu_data_q, cpu_data_d;

    logic                            hdr_err_inc, ovf_err_inc;
    logic                            tgt_full, tgt_enough;
    logic [3:0]                      hdr_magic, hdr_id;
    logic [LEN_W-1:0]                hdr_len;
    logic                            id_is_cpu, id_is_chan;
    logic [IQ_PAIR_WIDTH-1:0]        sample;

    assign hdr_magic  = data_i[MAGIC_LSB +: 4];
    assign hdr_id     = data_i[ID_LSB +: 4];
    assign hdr_len    = data_i[LEN_LSB +: LEN_W];
    assign id_is_cpu  = (hdr_id == CPU_ID);
    assign id_is_chan = (int'(hdr_id) < NUM_CH);
    assign sample     = {data_i[QSTART_BIT_INDEX +: HALF], data_i[HALF-1:0]};

    // Back-pressure of the packet's current target, irrespective of state.
    always_comb begin
        tgt_full   = 1'b0;
        tgt_enough = 1'b1;
        if (id_q == CPU_ID) begin
            tgt_full   = cpu_full_i;
            tgt_enough = ~cpu_full_i;
        end else begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (id_q == k[3:0]) begin
                    tgt_full   = fifo_full_i[k];
                    tgt_enough = fifo_enough_i[k];
                end
            end
        end
    end

    assign full_o   = (state_q == ST_PAYLOAD) ? tgt_full   : 1'b0;
    assign enough_o = (state_q == ST_PAYLOAD) ? tgt_enough : 1'b1;
    assign busy_o   = (state_q != ST_HDR);

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        id_d        = id_q;
        fifo_we_d   = '0;
        fifo_data_d = fifo_data_q;
        cpu_we_d    = 1'b0;
        cpu_data_d  = cpu_data_q;
        hdr_err_inc = 1'b0;
        ovf_err_inc = 1'b0;

        case (state_q)
            ST_HDR: begin
                if (we_i) begin
                    if (hdr_magic != HDR_MAGIC) begin
                        hdr_err_inc = 1'b1;
                    end else if (hdr_len != '0) begin
                        remaining_d = hdr_len;
                        id_d        = hdr_id;
                        if (id_is_chan || id_is_cpu) begin
                            state_d = ST_PAYLOAD;
                        end else begin
                            state_d     = ST_DROP;
                            hdr_err_inc = 1'b1;
                        end
                    end
                end
            end

            ST_PAYLOAD, ST_DROP: begin
                if (we_i) begin
                    // Every word counts toward the length, even if dropped,
                    // so framing survives overflow.
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = ST_HDR;
                    end
                    if (state_q == ST_PAYLOAD) begin
                        if (tgt_full) begin
                            ovf_err_inc = 1'b1;
                        end else if (id_q == CPU_ID) begin
                            cpu_we_d   = 1'b1;
                            cpu_data_d = data_i;
                        end else begin
                            for (int unsigned k = 0; k < NUM_CH; k++) begin
                                if (id_q == k[3:0]) begin
                                    fifo_we_d[k] = 1'b1;
                                    fifo_data_d[k*IQ_PAIR_WIDTH +: IQ_PAIR_WIDTH] = sample;
                                end
                            end
                        end
                    end
                end
            end

            default: state_d = ST_HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_HDR;
            remaining_q <= '0;
            id_q        <= '0;
            fifo_we_q   <= '0;
            fifo_data_q <= '0;
            cpu_we_q    <= 1'b0;
            cpu_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            id_q        <= id_d;
            fifo_we_q   <= fifo_we_d;
            fifo_data_q <= fifo_data_d;
            cpu_we_q    <= cpu_we_d;
            cpu_data_q  <= cpu_data_d;
        end
    end

    assign fifo_we_o   = fifo_we_q;
    assign fifo_data_o = fifo_data_q;
    assign cpu_we_o    = cpu_we_q;
    assign cpu_data_o  = cpu_data_q;

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_hdr_err (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (hdr_err_inc),
        .count_o (hdr_err_o)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_ovf_err (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (ovf_err_inc),
        .count_o (ovf_err_o)
    );

endmodule

// File: doc/ft_stream_demux.md
FT_STREAM_DEMUX -- requirements
Module: ft_stream_demux

Interface
REQ-001 SHALL have parameter FT_DATA_WIDTH, default 32: width of the FT600 read word.
REQ-002 SHALL have parameter IQ_PAIR_WIDTH, default 24: width of one {Q,I} sample written to an AFE TX FIFO (even, ≤ 2*QSTART_BIT_INDEX).
REQ-003 SHALL have parameter QSTART_BIT_INDEX, default 16: bit position of the Q field in a payload word.
REQ-004 SHALL have parameter NUM_CH, default 2: number of AFE TX channels (1..15).
REQ-005 SHALL have parameter CNT_WIDTH, default 16: width of the saturating error counters.
REQ-006 SHALL have the following ports.
- clk  in  1  single clock (FT600 clock domain).
- reset  in  1  synchronous reset, active-high.
- data_i  in  FT_DATA_WIDTH  word from the FT600 read path.
- we_i  in  1  data_i valid this cycle.
- full_o  out  1  cannot accept a word this cycle.
- enough_o  out  1  room for a full FT burst.
- fifo_full_i  in  NUM_CH  per-channel TX FIFO full.
- fifo_enough_i  in  NUM_CH  per-channel TX FIFO has burst room.
- fifo_data_o  out  NUM_CH*IQ_PAIR_WIDTH  per-channel sample, channel k at slice k.
- fifo_we_o  out  NUM_CH  per-channel write strobe.
- cpu_data_o  out  FT_DATA_WIDTH  control word for the soft CPU.
- cpu_we_o  out  1  control word strobe.
- cpu_full_i  in  1  CPU mailbox full.
- hdr_err_o  out  CNT_WIDTH  bad-header counter.
- ovf_err_o  out  CNT_WIDTH  words dropped due to full.
- busy_o  out  1  packet in progress.

Function
REQ-007 Header word SHALL be: [31:28]=4'hA magic, [27:24]=channel id, [15:0]=payload length L in words; other bits ignored.
REQ-008 States SHALL be HDR, PAYLOAD, DROP; busy_o=1 when state≠HDR.
REQ-009 In HDR, a written word with bad magic SHALL be discarded, hdr_err_o incremented, state stays HDR.
REQ-010 In HDR, a valid header with L=0 SHALL be consumed with no state change.
REQ-011 In HDR, a valid header with L>0 SHALL load remaining=L and go to PAYLOAD if id<NUM_CH or id==15 (CPU), else to DROP with hdr_err_o incremented.
REQ-012 In PAYLOAD, each accepted word SHALL decrement remaining; on the word with remaining==1 state returns to HDR next cycle.
REQ-013 Channel payload: fifo_data_o slice SHALL be {data_i[QSTART_BIT_INDEX+IQ_PAIR_WIDTH/2-1:QSTART_BIT_INDEX], data_i[IQ_PAIR_WIDTH/2-1:0]}, with fifo_we_o[id] pulsed for one cycle.
REQ-014 CPU payload SHALL drive cpu_data_o=data_i with cpu_we_o pulsed.
REQ-015 Output latency SHALL be exactly one clock from the accepted we_i; outputs registered; at most one strobe high per cycle.
REQ-016 full_o SHALL be 0 in HDR and DROP; in PAYLOAD it SHALL equal the target's full input (fifo_full_i[id] or cpu_full_i), combinationally.
REQ-017 enough_o SHALL be 1 in HDR and DROP; in PAYLOAD it SHALL equal fifo_enough_i[id] (CPU target: ~cpu_full_i).
REQ-018 A word with we_i=1 while full_o=1 SHALL be discarded, SHALL still decrement remaining, and SHALL increment ovf_err_o (keeps framing).
REQ-019 In DROP, words SHALL be discarded and counted down as in PAYLOAD, with no strobes.
REQ-020 Counters SHALL saturate at all-ones; both counters incrementing on the same cycle is impossible by construction.
REQ-021 Undriven data outputs SHALL hold their last value; strobes default 0.

Reset
REQ-022 On reset: state=HDR, remaining=0, fifo_we_o=0, cpu_we_o=0, fifo_data_o=0, cpu_data_o=0, hdr_err_o=0, ovf_err_o=0.
REQ-023 Reset mid-packet SHALL abandon the packet; the next accepted word is parsed as a header.

Structure
REQ-024 Header magic, field positions, CPU id 15 and state encoding SHALL live in a shared package sdr_pkg.
REQ-025 A sub-module sat_counter (CNT_WIDTH, saturating increment, synchronous clear) SHALL be instanced for both error counters.

Verification
REQ-026 Header 0xA0000003 + words 0x0ABC0123, 0x0FFF0000, 0x00010FFF -> fifo_we_o[0] three times, data 0xABC123, 0xFFF000, 0x001FFF, one cycle late, then HDR.
REQ-027 Header 0xAF000001 + 0xDEADBEEF -> cpu_we_o once with 0xDEADBEEF; no fifo_we_o.
REQ-028 Word 0x12345678 in HDR -> hdr_err_o=1, no strobes; header 0xA7000002 (NUM_CH=2) + 2 words -> DROP, hdr_err_o=2, no strobes, then HDR.
REQ-029 Channel 1 packet L=4 with fifo_full_i[1]=1 on word 2 -> full_o=1 that cycle, 3 writes, ovf_err_o=1, next word parsed as header.
REQ-030 Reset asserted after 2 of 5 payload words -> all outputs at reset values; following 0xA0000001 + word processed normally.
